// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the front-end branch predictor.
//   - 2-bit saturating counter encodings
//   - not-taken fall-through offset
//   - default table index widths
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken (reset value)
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken (fresh allocation)
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // Must equal the not-taken address produced at resolution so a correct
  // not-taken prediction never causes a redirect.
  localparam logic [31:0] NT_OFFSET = 32'd8;

  localparam int BHT_IDX_W_DEF = 8;
  localparam int BTB_IDX_W_DEF = 6;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// bp_sat_counter2: combinational next-state function of a 2-bit saturating
// direction counter.
//   taken    in  1  resolved direction
//   cnt      in  2  current counter value
//   cnt_next out 2  counter value after training
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       taken,
  input  logic [1:0] cnt,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus PC-indexed table of 2-bit
// saturating counters, with a registered (1-cycle) prediction output.
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_valid, fetch_pc       lookup request
//   stall                       hold prediction outputs
//   flush                       drop the in-flight prediction (beats stall)
//   pred_valid/pc/taken/addr    registered prediction
//   update_en/pc/taken/target   training from branch resolution
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = BHT_IDX_W_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_addr,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  // Tables (flop arrays so reset clears them)
  logic [BHT_N-1:0][1:0] cnt_q, cnt_d;
  logic [BTB_N-1:0]      btb_vld_q, btb_vld_d;
  logic [TAG_W-1:0]      btb_tag_q [BTB_N];
  logic [TAG_W-1:0]      btb_tag_d [BTB_N];
  logic [31:0]           btb_tgt_q [BTB_N];
  logic [31:0]           btb_tgt_d [BTB_N];

  // Output register
  logic        pred_valid_q, pred_valid_d;
  logic [31:0] pred_pc_q, pred_pc_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_addr_q, pred_addr_d;

  // Lookup side
  logic [BHT_IDX_W-1:0] f_bht_idx;
  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_tag;
  logic                 f_hit;
  logic                 f_taken;
  logic [31:0]          f_addr;

  // Update side
  logic [BHT_IDX_W-1:0] u_bht_idx;
  logic [BTB_IDX_W-1:0] u_btb_idx;
  logic [TAG_W-1:0]     u_tag;
  logic                 u_hit;
  logic [1:0]           u_cnt_next;

  // PCs are word aligned; the low two bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

  assign f_bht_idx = fetch_pc[BHT_IDX_W+1:2];
  assign f_btb_idx = fetch_pc[BTB_IDX_W+1:2];
  assign f_tag     = fetch_pc[31:BTB_IDX_W+2];

  assign u_bht_idx = update_pc[BHT_IDX_W+1:2];
  assign u_btb_idx = update_pc[BTB_IDX_W+1:2];
  assign u_tag     = update_pc[31:BTB_IDX_W+2];

  // Lookup reads the registered tables only, so a same-cycle update to the
  // same entry is not visible until the following cycle.
  always_comb begin
    f_hit   = btb_vld_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
    f_taken = f_hit && cnt_q[f_bht_idx][1];
    f_addr  = f_taken ? btb_tgt_q[f_btb_idx] : fetch_pc + NT_OFFSET;
  end

  assign u_hit = btb_vld_q[u_btb_idx] && (btb_tag_q[u_btb_idx] == u_tag);

  bp_sat_counter2 u_sat (
    .taken    (update_taken),
    .cnt      (cnt_q[u_bht_idx]),
    .cnt_next (u_cnt_next)
  );

  // Training: taken hits refresh the target, taken misses allocate and
  // seed the counter at weakly-taken, not-taken only moves the counter.
  always_comb begin
    cnt_d     = cnt_q;
    btb_vld_d = btb_vld_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (update_en) begin
      if (update_taken) begin
        btb_tgt_d[u_btb_idx] = update_target;
        if (u_hit) begin
          cnt_d[u_bht_idx] = u_cnt_next;
        end else begin
          btb_vld_d[u_btb_idx] = 1'b1;
          btb_tag_d[u_btb_idx] = u_tag;
          cnt_d[u_bht_idx]     = CNT_WT;
        end
      end else begin
        cnt_d[u_bht_idx] = u_cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= {BHT_N{CNT_WNT}};
      btb_vld_q <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      btb_vld_q <= btb_vld_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
    end
  end

  // Output register: flush > stall > load
  always_comb begin
    pred_valid_d = pred_valid_q;
    pred_pc_d    = pred_pc_q;
    pred_taken_d = pred_taken_q;
    pred_addr_d  = pred_addr_q;
    if (flush) begin
      pred_valid_d = 1'b0;
    end else if (!stall) begin
      pred_valid_d = fetch_valid;
      pred_pc_d    = fetch_pc;
      pred_taken_d = f_taken;
      pred_addr_d  = f_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_taken_q <= 1'b0;
      pred_addr_q  <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_pc_q    <= pred_pc_d;
      pred_taken_q <= pred_taken_d;
      pred_addr_q  <= pred_addr_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_pc    = pred_pc_q;
  assign pred_taken = pred_taken_q;
  assign pred_addr  = pred_addr_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .stall         (stall),
    .flush         (flush),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_addr     (pred_addr),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: tables as plain arrays, counters as integers 0..3.
  bit          m_v   [64];
  int unsigned m_tag [64];
  bit [31:0]   m_tgt [64];
  int          m_cnt [256];

  // Expected output-register contents; "known" means pc/taken/addr matter.
  typedef struct {
    bit        known;
    bit        vld;
    bit [31:0] pc;
    bit        tk;
    bit [31:0] addr;
  } exp_t;

  exp_t cur;
  exp_t sb[$];

  function automatic void mdl_reset();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0;
    end
    for (int i = 0; i < 256; i++) m_cnt[i] = 1;
    cur.known = 1'b1; cur.vld = 1'b0; cur.pc = '0; cur.tk = 1'b0; cur.addr = '0;
  endfunction

  function automatic void mdl_lookup(input bit [31:0] pc, output bit tk, output bit [31:0] a);
    int unsigned w  = pc >> 2;
    int          bi = int'(w % 64);
    int          ci = int'(w % 256);
    bit          hit = m_v[bi] && (m_tag[bi] == (pc >> 8));
    tk = hit && (m_cnt[ci] >= 2);
    a  = tk ? m_tgt[bi] : pc + 32'd8;
  endfunction

  function automatic void mdl_update(input bit [31:0] pc, input bit t, input bit [31:0] tgt);
    int unsigned w  = pc >> 2;
    int          bi = int'(w % 64);
    int          ci = int'(w % 256);
    bit          hit = m_v[bi] && (m_tag[bi] == (pc >> 8));
    if (t) begin
      m_tgt[bi] = tgt;
      if (hit) begin
        if (m_cnt[ci] < 3) m_cnt[ci]++;
      end else begin
        m_v[bi] = 1'b1; m_tag[bi] = pc >> 8; m_cnt[ci] = 2;
      end
    end else if (m_cnt[ci] > 0) begin
      m_cnt[ci]--;
    end
  endfunction

  // One clock of stimulus: drive at negedge, predict the register contents
  // after the coming posedge, push the prediction for the monitor.
  task automatic step(input bit r, input bit fv, input bit [31:0] pc, input bit st,
                      input bit fl, input bit ue, input bit [31:0] upc, input bit ut,
                      input bit [31:0] utgt);
    bit        tk;
    bit [31:0] a;
    @(negedge clk);
    rst_n = r; fetch_valid = fv; fetch_pc = pc; stall = st; flush = fl;
    update_en = ue; update_pc = upc; update_taken = ut; update_target = utgt;
    if (!r) begin
      mdl_reset();
    end else begin
      if (fl) begin
        cur.vld = 1'b0; cur.known = 1'b0;
      end else if (!st) begin
        mdl_lookup(pc, tk, a);
        cur.vld = fv; cur.known = fv; cur.pc = pc; cur.tk = tk; cur.addr = a;
      end
      if (ue) mdl_update(upc, ut, utgt);
    end
    sb.push_back(cur);
  endtask

  task automatic look(input bit [31:0] pc);
    step(1, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic upd(input bit [31:0] pc, input bit t, input bit [31:0] tgt);
    step(1, 0, 0, 0, 0, 1, pc, t, tgt);
  endtask
  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Directed check against constants from the test plan (outputs are stable
  // between the negedge drive and the next posedge).
  task automatic chk(input string name, input bit vld, input bit tk, input bit [31:0] a);
    n_total++;
    if (pred_valid === vld && (!vld || (pred_taken === tk && pred_addr === a))) n_pass++;
    else $display("FAIL %s: got vld=%0b tk=%0b addr=%08h, want vld=%0b tk=%0b addr=%08h",
                  name, pred_valid, pred_taken, pred_addr, vld, tk, a);
  endtask

  // Monitor: compares every registered output cycle with the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if (pred_valid === e.vld) n_pass++;
      else $display("FAIL sb_valid: got %0b want %0b at %0t", pred_valid, e.vld, $time);
      if (e.known) begin
        n_total++;
        if (pred_pc === e.pc && pred_taken === e.tk && pred_addr === e.addr) n_pass++;
        else $display("FAIL sb_fields: got pc=%08h tk=%0b addr=%08h want pc=%08h tk=%0b addr=%08h at %0t",
                      pred_pc, pred_taken, pred_addr, e.pc, e.tk, e.addr, $time);
      end
    end
  end

  localparam bit [31:0] PA = 32'h1c000100;
  localparam bit [31:0] PB = 32'h1c000200;
  localparam bit [31:0] PC3 = 32'h1c000300;

  initial begin
    bit [31:0] rp, up;
    mdl_reset();
    // reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, PA, 0, 0, 1, PA, 1, 32'h1c000200);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_state", 1'b0, 1'b0, 32'h0);
    // cold lookup
    look(PA); idle(); chk("cold_lookup", 1, 0, 32'h1c000108);
    // one taken update then two not-taken
    upd(PA, 1, 32'h1c000200);
    look(PA); idle(); chk("trained_taken", 1, 1, 32'h1c000200);
    upd(PA, 0, 0); upd(PA, 0, 0);
    look(PA); idle(); chk("after_two_nt", 1, 0, 32'h1c000108);
    // saturation high
    repeat (5) upd(PA, 1, 32'h1c000200);
    upd(PA, 0, 0);
    look(PA); idle(); chk("sat_high", 1, 1, 32'h1c000200);
    // saturation low
    repeat (5) upd(PA, 0, 0);
    upd(PA, 1, 32'h1c000200);
    look(PA); idle(); chk("sat_low", 1, 0, 32'h1c000108);
    // alias on the BTB index
    upd(PA, 1, 32'h1c000200);
    look(PB); idle(); chk("alias_miss", 1, 0, 32'h1c000208);
    upd(PB, 1, 32'h1c000400);
    look(PB); idle(); chk("alias_replaced", 1, 1, 32'h1c000400);
    look(PA); idle(); chk("alias_evicted", 1, 0, 32'h1c000108);
    // same-cycle update and lookup
    step(1, 1, PC3, 0, 0, 1, PC3, 1, 32'h1c000500);
    look(PC3); chk("same_cycle_old", 1, 0, 32'h1c000308);
    idle(); chk("next_cycle_new", 1, 1, 32'h1c000500);
    // stall holds for three cycles
    look(PC3);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, PA + 32'(i * 4), 1, 0, 0, 0, 0, 0);
      chk("stall_hold", 1, 1, 32'h1c000500);
    end
    step(1, 1, PA, 1, 1, 0, 0, 0, 0);
    idle(); chk("flush_over_stall", 0, 0, 32'h0);
    // reset pulse after training
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_reset_outputs", 1'b0, 1'b0, 32'h0);
    look(PC3); look(PB); chk("post_reset_c3", 1, 0, 32'h1c000308);
    idle(); chk("post_reset_b", 1, 0, 32'h1c000208);
    // randomized traffic on a small PC pool to force hits and aliasing
    for (int i = 0; i < 1500; i++) begin
      rp = 32'h1c000000 + (32'($urandom_range(0, 1)) << 12) + (32'($urandom_range(0, 95)) << 2);
      up = 32'h1c000000 + (32'($urandom_range(0, 1)) << 12) + (32'($urandom_range(0, 95)) << 2);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 8), rp,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), up, $urandom_range(0, 1) == 1,
           {$urandom} & 32'hfffffffc);
    end
    idle();
    @(posedge clk); #3;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Front-end branch predictor: the fetch-side counterpart to the execute-stage branch resolution logic. Given a fetch PC it returns a registered taken/not-taken prediction and next-fetch address, consumed downstream as the predicted taken flag and predicted target carried with the instruction. The block is trained by the resolution stage's update interface (update enable, PC, actual taken, actual target). It combines a direct-mapped BTB with a PC-indexed table of 2-bit saturating counters.

## Interface
- `BHT_IDX_W`, default 8: log2 of counter table entries (256).
- `BTB_IDX_W`, default 6: log2 of BTB entries (64). Tag width is 30-BTB_IDX_W.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  `fetch_pc` is valid this cycle.
- `fetch_pc`  in  32  fetch address, word aligned.
- `stall`  in  1  hold prediction outputs.
- `flush`  in  1  discard the in-flight prediction.
- `pred_valid`  out  1  prediction outputs are valid.
- `pred_pc`  out  32  PC the prediction belongs to.
- `pred_taken`  out  1  predicted taken.
- `pred_addr`  out  32  predicted next address.
- `update_en`  in  1  train with a resolved branch.
- `update_pc`  in  32  PC of the resolved branch.
- `update_taken`  in  1  actual direction.
- `update_target`  in  32  actual taken target.

## Operation
- Counter index is `pc[BHT_IDX_W+1:2]`. BTB index is `pc[BTB_IDX_W+1:2]`; BTB tag is `pc[31:BTB_IDX_W+2]`. A BTB entry holds valid, tag and target.
- Lookup: hit = entry valid && tag match. `pred_taken` = hit && counter[1]. `pred_addr` = target if `pred_taken`, else `fetch_pc + 8`. The +8 exactly matches the not-taken address produced at resolution, so a correct not-taken prediction never flushes.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Update, taken, BTB hit: overwrite the target with `update_target`; counter increments.
- Update, taken, BTB miss: allocate by writing valid, tag and target. Force the counter to 10, so one taken outcome predicts taken.
- Update, not taken: BTB unchanged; counter decrements.
- Unconditional branches (B, BL, JIRL) arrive as taken updates and are handled identically.
- A lookup and an update in the same cycle to the same entry: the lookup sees pre-update contents. There is no bypass.
- `fetch_valid`=0 with no stall or flush: `pred_valid` goes to 0 next cycle; other outputs don't-care.

## Timing
- Registered outputs with 1-cycle latency: a lookup presented in cycle N appears on the outputs in N+1.
- Output register priority:
  1. `flush` forces `pred_valid`=0 next cycle; `flush` wins over `stall`.
  2. Otherwise `stall` holds all outputs unchanged.
  3. Otherwise the outputs load the new lookup.
- Table writes commit at the rising edge where `update_en`=1; `stall` and `flush` do not block updates. A write is visible to lookups from the next cycle.
- Reset values:
  - Outputs: `pred_valid`=0, `pred_taken`=0, `pred_pc`=0, `pred_addr`=0.
  - Tables: all BTB valid bits 0; all counters 01.
- Asserting `rst_n` low mid-operation clears outputs and tables immediately. An update coincident with reset is dropped.

## Structure
- Shared package: counter encoding constants (`CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`), the not-taken fall-through offset (8), and default index widths.
- One sub-module: `bp_sat_counter2`, a combinational 2-bit saturating next-state function (taken, current -> next). Table storage and the output register stay in the top module.
- Tables are flop arrays so async reset can clear them; no RAM macro.

## Test plan
- Reset, then lookup 0x1c000100 -> next cycle `pred_valid`=1, `pred_taken`=0, `pred_addr`=0x1c000108.
- One taken update for pc 0x1c000100 to target 0x1c000200, then lookup -> `pred_taken`=1, `pred_addr`=0x1c000200. Two not-taken updates, then lookup -> `pred_taken`=0, `pred_addr`=0x1c000108.
- Saturation:
  - Five taken updates then one not-taken -> still taken (counter 10).
  - Five not-taken updates then one taken -> still not taken (counter 01).
- Alias: train 0x1c000100 taken, then look up 0x1c000200 (same BTB index, different tag) -> miss, `pred_addr`=0x1c000208. Then update 0x1c000200 taken to 0x1c000400 -> entry replaced; a lookup of 0x1c000100 now misses.
- Same-cycle update and lookup of an untrained 0x1c000300 -> not taken (old contents); the next-cycle lookup -> taken.
- Handshake and reset:
  - `stall` for 3 cycles -> outputs constant.
  - `flush` together with `stall` -> `pred_valid`=0.
  - `rst_n` pulsed low after training -> all lookups not taken.
